// File: rtl/tx_resp_pkg.sv
// rtl/tx_resp_pkg.sv - shared types and widths for the TX response arbiter
package tx_resp_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_RF     = 2'd1,
    ST_SEND_ALU_LO = 2'd2,
    ST_SEND_ALU_HI = 2'd3
  } state_t;

  typedef enum logic {
    SRC_RF  = 1'b0,
    SRC_ALU = 1'b1
  } src_t;

endpackage

// File: rtl/resp_hold.sv
// rtl/resp_hold.sv - one-entry holding buffer for a single result source
//   clk, rst       : clock, synchronous active-high reset
//   valid, data    : one-cycle result pulse and its payload
//   rel            : buffer contents consumed this cycle
//   held, pending  : stored payload and occupancy
//   drop           : pulse arrived while full and not being consumed
module resp_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             rel,
  output logic [WIDTH-1:0] held,
  output logic             pending,
  output logic             drop
);

  logic accept;

  // A slot freed in the same cycle can take the new pulse.
  assign accept = valid && (!pending || rel);
  assign drop   = valid && pending && !rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      held    <= '0;
      pending <= 1'b0;
    end else if (accept) begin
      held    <= data;
      pending <= 1'b1;
    end else if (rel) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_resp_arbiter.sv
// rtl/tx_resp_arbiter.sv - round-robin RF/ALU response arbiter onto the TX FIFO write port
//   CLK, RST             : REF_CLK domain clock, synchronous active-high reset
//   RF_DATA, RF_VALID    : register-file read result pulse
//   ALU_DATA, ALU_VALID  : ALU result pulse, sent LSB byte then MSB byte
//   FIFO_FULL            : FIFO write-side back-pressure
//   WR_DATA, WR_INC      : FIFO write byte and strobe
//   RF_READY, ALU_READY  : holding buffer empty
//   BUSY                 : frame in progress or result pending
//   OVF                  : sticky, a result pulse was dropped
module tx_resp_arbiter
  import tx_resp_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W,
  parameter int ALU_WIDTH  = HALF_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RF_DATA,
  input  logic                  RF_VALID,
  input  logic [ALU_WIDTH-1:0]  ALU_DATA,
  input  logic                  ALU_VALID,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_INC,
  output logic                  RF_READY,
  output logic                  ALU_READY,
  output logic                  BUSY,
  output logic                  OVF
);

  state_t                state_q, state_d;
  src_t                  last_grant_q, last_grant_d;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] rf_held;
  logic [ALU_WIDTH-1:0]  alu_held;
  logic                  rf_pending, alu_pending;
  logic                  rf_drop, alu_drop;
  logic                  rf_rel, alu_rel;
  logic                  rf_avail, alu_avail;
  logic                  decide;

  assign rf_rel  = WR_INC && (state_q == ST_SEND_RF);
  assign alu_rel = WR_INC && (state_q == ST_SEND_ALU_HI);

  // A buffer whose last byte goes out this cycle must not be re-granted.
  assign rf_avail  = rf_pending && !rf_rel;
  assign alu_avail = alu_pending && !alu_rel;

  resp_hold #(.WIDTH(DATA_WIDTH)) u_rf_hold (
    .clk     (CLK),
    .rst     (RST),
    .valid   (RF_VALID),
    .data    (RF_DATA),
    .rel     (rf_rel),
    .held    (rf_held),
    .pending (rf_pending),
    .drop    (rf_drop)
  );

  resp_hold #(.WIDTH(ALU_WIDTH)) u_alu_hold (
    .clk     (CLK),
    .rst     (RST),
    .valid   (ALU_VALID),
    .data    (ALU_DATA),
    .rel     (alu_rel),
    .held    (alu_held),
    .pending (alu_pending),
    .drop    (alu_drop)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_ALU;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_q | rf_drop | alu_drop;
    end
  end

  // Grants happen from IDLE or on the final byte of a frame, so frames
  // chain back to back; the LO byte always proceeds to the HI byte.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    decide       = 1'b0;
    case (state_q)
      ST_IDLE:        decide = 1'b1;
      ST_SEND_RF:     decide = WR_INC;
      ST_SEND_ALU_LO: if (WR_INC) state_d = ST_SEND_ALU_HI;
      ST_SEND_ALU_HI: decide = WR_INC;
      default:        state_d = ST_IDLE;
    endcase
    if (decide) begin
      if (rf_avail && (!alu_avail || last_grant_q == SRC_ALU)) begin
        state_d      = ST_SEND_RF;
        last_grant_d = SRC_RF;
      end else if (alu_avail) begin
        state_d      = ST_SEND_ALU_LO;
        last_grant_d = SRC_ALU;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    WR_INC  = (state_q != ST_IDLE) && !FIFO_FULL;
    WR_DATA = '0;
    case (state_q)
      ST_SEND_RF:     WR_DATA = rf_held;
      ST_SEND_ALU_LO: WR_DATA = alu_held[DATA_WIDTH-1:0];
      ST_SEND_ALU_HI: WR_DATA = alu_held[ALU_WIDTH-1:DATA_WIDTH];
      default:        WR_DATA = '0;
    endcase
  end

  assign RF_READY  = !rf_pending;
  assign ALU_READY = !alu_pending;
  assign BUSY      = (state_q != ST_IDLE) || rf_pending || alu_pending;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// tb/tb_tx_resp_arbiter.sv - self-checking bench for tx_resp_arbiter
module tb_tx_resp_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RF_DATA = '0;
  logic        RF_VALID = 1'b0;
  logic [15:0] ALU_DATA = '0;
  logic        ALU_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC, RF_READY, ALU_READY, BUSY, OVF;

  tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RF_DATA   (RF_DATA),
    .RF_VALID  (RF_VALID),
    .ALU_DATA  (ALU_DATA),
    .ALU_VALID (ALU_VALID),
    .FIFO_FULL (FIFO_FULL),
    .WR_DATA   (WR_DATA),
    .WR_INC    (WR_INC),
    .RF_READY  (RF_READY),
    .ALU_READY (ALU_READY),
    .BUSY      (BUSY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: each source holds at most one result; a granted
  // result becomes a queue of bytes still to be written to the FIFO.
  bit          m_rf_p, m_alu_p, m_ovf;
  logic [7:0]  m_rf_d;
  logic [15:0] m_alu_d;
  bit          m_last_alu = 1'b1;
  bit          m_cur_alu;
  logic [7:0]  frame[$];

  logic [7:0]  wlog[$];
  logic        s_inc, s_busy, s_rrdy, s_ardy, s_ovf;
  logic [7:0]  s_data;

  task automatic model_tick(input bit rv, input logic [7:0] rd, input bit av,
                            input logic [15:0] ad, input bit full, input bit r);
    bit decide, rf_rel, alu_rel, ra, aa, pick_alu;
    if (r) begin
      m_rf_p = 0; m_alu_p = 0; m_ovf = 0; m_last_alu = 1; frame.delete();
      m_rf_d = '0; m_alu_d = '0;
      return;
    end
    rf_rel = 0; alu_rel = 0;
    decide = (frame.size() == 0);
    if (frame.size() > 0 && !full) begin
      void'(frame.pop_front());
      if (frame.size() == 0) begin
        if (m_cur_alu) alu_rel = 1; else rf_rel = 1;
        decide = 1;
      end
    end
    if (decide) begin
      ra = m_rf_p && !rf_rel;
      aa = m_alu_p && !alu_rel;
      pick_alu = (ra && aa) ? !m_last_alu : aa;
      if (ra || aa) begin
        if (pick_alu) begin
          frame.push_back(m_alu_d[7:0]);
          frame.push_back(m_alu_d[15:8]);
        end else begin
          frame.push_back(m_rf_d);
        end
        m_cur_alu  = pick_alu;
        m_last_alu = pick_alu;
      end
    end
    if (rv) begin
      if (!m_rf_p || rf_rel) begin m_rf_d = rd; m_rf_p = 1; end
      else m_ovf = 1;
    end else if (rf_rel) m_rf_p = 0;
    if (av) begin
      if (!m_alu_p || alu_rel) begin m_alu_d = ad; m_alu_p = 1; end
      else m_ovf = 1;
    end else if (alu_rel) m_alu_p = 0;
  endtask

  task automatic step(input bit rv, input logic [7:0] rd, input bit av,
                      input logic [15:0] ad, input bit full, input bit r);
    logic       e_inc;
    logic [7:0] e_data;
    @(negedge CLK);
    RF_VALID = rv; RF_DATA = rd; ALU_VALID = av; ALU_DATA = ad;
    FIFO_FULL = full; RST = r;
    #1;
    e_inc  = (frame.size() > 0) && !full;
    e_data = (frame.size() > 0) ? frame[0] : 8'h00;
    s_inc = WR_INC; s_data = WR_DATA; s_busy = BUSY;
    s_rrdy = RF_READY; s_ardy = ALU_READY; s_ovf = OVF;
    check("wr_inc", WR_INC, e_inc);
    check("wr_data", WR_DATA, e_data);
    check("busy", BUSY, (frame.size() > 0) || m_rf_p || m_alu_p);
    check("rf_ready", RF_READY, !m_rf_p);
    check("alu_ready", ALU_READY, !m_alu_p);
    check("ovf", OVF, m_ovf);
    if (WR_INC) wlog.push_back(WR_DATA);
    @(posedge CLK);
    model_tick(rv, rd, av, ad, full, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 16'h0000, 0, 0);
  endtask

  task automatic check_log(input string tag, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] e[3];
    e[0] = b0; e[1] = b1; e[2] = b2;
    check({tag, "_len"}, wlog.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), (i < wlog.size()) ? wlog[i] : 8'hxx, e[i]);
    wlog.delete();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_wr_inc", WR_INC, 0);
    check("rst_wr_data", WR_DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_rf_ready", RF_READY, 1);
    check("rst_alu_ready", ALU_READY, 1);
    check("rst_ovf", OVF, 0);

    // single RF byte
    step(1, 8'h5A, 0, 16'h0000, 0, 0);
    idle(4);
    check("rf_done_busy", s_busy, 0);
    check_log("rf", 1, 8'h5A, 8'h00, 8'h00);

    // single ALU pair
    step(0, 8'h00, 1, 16'hBEEF, 0, 0);
    idle(5);
    check_log("alu", 2, 8'hEF, 8'hBE, 8'h00);

    // simultaneous pair after reset state: RF first
    step(1, 8'h11, 1, 16'h2233, 0, 0);
    idle(6);
    check_log("pair1", 3, 8'h11, 8'h33, 8'h22);

    // RF-only grant moves the pointer to RF, so the next tie goes to ALU
    step(1, 8'h77, 0, 16'h0000, 0, 0);
    idle(4);
    check_log("rf77", 1, 8'h77, 8'h00, 8'h00);
    step(1, 8'h44, 1, 16'h5566, 0, 0);
    idle(6);
    check_log("pair2", 3, 8'h66, 8'h55, 8'h44);

    // back-pressure stall on the LSB byte
    step(0, 8'h00, 1, 16'hCAFE, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 16'h0000, 1, 0);
      check("stall_inc", s_inc, 0);
      check("stall_data", s_data, 8'hFE);
    end
    idle(4);
    check_log("stall", 2, 8'hFE, 8'hCA, 8'h00);

    // overflow while blocked
    step(1, 8'h01, 0, 16'h0000, 1, 0);
    step(1, 8'h02, 0, 16'h0000, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 16'h0000, 1, 0);
    check("ovf_set", s_ovf, 1);
    idle(4);
    check("ovf_sticky", s_ovf, 1);
    check_log("ovf", 1, 8'h01, 8'h00, 8'h00);

    // reset during the MSB byte
    step(0, 8'h00, 1, 16'h1234, 0, 0);
    idle(2);
    step(0, 8'h00, 0, 16'h0000, 0, 1);
    wlog.delete();
    idle(1);
    check("mrst_inc", s_inc, 0);
    check("mrst_busy", s_busy, 0);
    check("mrst_rrdy", s_rrdy, 1);
    check("mrst_ardy", s_ardy, 1);
    check("mrst_ovf", s_ovf, 0);
    idle(5);
    check_log("mrst", 0, 8'h00, 8'h00, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) == 0,
           16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    idle(10);
    check("final_busy", s_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
